// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN     = 32'd8;
  localparam int unsigned DEF_CNT_W       = 32'd16;
  localparam logic [7:0]  DEF_RST_PATTERN = 8'b0000_1010;
  localparam int unsigned DEF_RST_LEN     = 32'd4;
  localparam logic        DEF_RST_OVERLAP = 1'b1;

  // A pattern length is usable only in 1..max_len.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 32'd1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_cfg.sv
// Active configuration registers for the detector: legality check on load
// and a one-cycle error pulse when a load is rejected.
module seq_det_cfg
  import seq_det_pkg::*;
#(
  parameter int unsigned          MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned          LEN_W       = $clog2(MAX_LEN) + 1,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int unsigned          RST_LEN     = DEF_RST_LEN,
  parameter logic                 RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  output logic [MAX_LEN-1:0] pat_o,
  output logic [LEN_W-1:0]   len_o,
  output logic               ovl_o,
  output logic               cfg_apply_o,
  output logic               cfg_err_o
);

  logic               legal_s;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;

  assign legal_s     = len_legal(32'(cfg_len_i), MAX_LEN);
  assign cfg_apply_o = cfg_load_i & legal_s;

  // Next configuration: a rejected load keeps the old fields and flags an error.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    err_d = 1'b0;
    if (cfg_load_i) begin
      if (legal_s) begin
        pat_d = cfg_pattern_i;
        len_d = cfg_len_i;
        ovl_d = cfg_overlap_i;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Configuration and error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q <= RST_PATTERN;
      len_q <= LEN_W'(RST_LEN);
      ovl_q <= RST_OVERLAP;
      err_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      err_q <= err_d;
    end
  end

  assign pat_o     = pat_q;
  assign len_o     = len_q;
  assign ovl_o     = ovl_q;
  assign cfg_err_o = err_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Mealy match flag) with
// overlap control and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned          LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int unsigned          CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int unsigned          RST_LEN     = DEF_RST_LEN,
  parameter logic                 RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               d_valid,
  input  logic               d_in,
  input  logic               cnt_clr,
  output logic               seq_det,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam int unsigned HIST_W = MAX_LEN - 1;

  logic [MAX_LEN-1:0] pat_s;
  logic [LEN_W-1:0]   len_s;
  logic               ovl_s;
  logic               cfg_apply_s;

  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept_s;
  logic               fill_ok_s;
  logic               match_s;
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;

  seq_det_cfg #(
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W),
    .RST_PATTERN (RST_PATTERN),
    .RST_LEN     (RST_LEN),
    .RST_OVERLAP (RST_OVERLAP)
  ) u_cfg (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .pat_o         (pat_s),
    .len_o         (len_s),
    .ovl_o         (ovl_s),
    .cfg_apply_o   (cfg_apply_s),
    .cfg_err_o     (cfg_err)
  );

  // A bit presented alongside cfg_load is dropped.
  assign accept_s  = d_valid & ~cfg_load;
  assign window_s  = {hist_q, d_in};
  assign fill_ok_s = (fill_q + LEN_W'(1)) >= len_s;

  // Select the low len_s bits of the window for comparison.
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask_s[i] = (i < int'(len_s));
    end
  end

  assign match_s = accept_s & fill_ok_s & ((window_s & mask_s) == (pat_s & mask_s));
  assign seq_det = match_s & ~rst;

  // History/fill next state; non-overlap matches empty the history logically.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_apply_s) begin
      hist_d = {HIST_W{1'b0}};
      fill_d = {LEN_W{1'b0}};
    end else if (accept_s) begin
      hist_d = window_s[HIST_W-1:0];
      if (match_s && !ovl_s) begin
        fill_d = {LEN_W{1'b0}};
      end else if (fill_q < LEN_W'(HIST_W)) begin
        fill_d = fill_q + LEN_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // Saturating match counter; clear wins over a coincident match.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= {HIST_W{1'b0}};
      fill_q <= {LEN_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_seq_detector_param;

  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst, cfg_load, cfg_overlap, d_valid, d_in, cnt_clr;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        det_a, det_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .d_valid(d_valid), .d_in(d_in),
    .cnt_clr(cnt_clr), .seq_det(det_a), .match_cnt(cnt_a), .cfg_err(err_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .d_valid(d_valid), .d_in(d_in),
    .cnt_clr(cnt_clr), .seq_det(det_b), .match_cnt(cnt_b), .cfg_err(err_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the accepted bits since the last clear, held as a queue.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt_a, m_cnt_b;
  bit         m_err;
  bit         m_valid = 1'b0;

  always @(negedge clk) begin
    bit w[$];
    bit m;
    bit acc;
    m = 1'b0;
    if (m_valid) begin
      chk("model_cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      chk("model_cnt_b", 32'(cnt_b), 32'(m_cnt_b));
      chk("model_err_a", 32'(err_a), 32'(m_err));
      chk("model_err_b", 32'(err_b), 32'(m_err));
    end
    if (rst) begin
      chk("model_det_rst", 32'(det_a), 32'd0);
      mq.delete();
      m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1'b1;
      m_cnt_a = 0; m_cnt_b = 0; m_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      acc = d_valid && !cfg_load;
      w = mq;
      if (acc) begin
        w.push_back(d_in);
        if (w.size() >= m_len) begin
          m = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (w[w.size() - 1 - k] != m_pat[k]) m = 1'b0;
        end
      end
      chk("model_det_a", 32'(det_a), 32'(m));
      chk("model_det_b", 32'(det_b), 32'(m));
      if (cnt_clr) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (m) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
      m_err = cfg_load && (cfg_len < 4'd1 || cfg_len > 4'd8);
      if (cfg_load) begin
        if (!m_err) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          mq.delete();
        end
      end else if (acc) begin
        if (m && !m_ovl) mq.delete();
        else begin
          mq = w;
          while (mq.size() > ML - 1) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic idle_in();
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    cfg_overlap = 1'b0; d_valid = 1'b0; d_in = 1'b0; cnt_clr = 1'b0;
  endtask

  // Inputs are set at posedge+1; seq_det is sampled 3 time units later.
  task automatic go(input logic exp, input string nm);
    #3;
    chk(nm, 32'(det_a), 32'(exp));
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic bitv(input logic b, input logic exp, input string nm);
    d_valid = 1'b1; d_in = b;
    go(exp, nm);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    go(1'b0, "load_det");
  endtask

  task automatic stream(input logic [7:0] bits, input logic [7:0] exps, input int n, input string nm);
    for (int i = n - 1; i >= 0; i--) bitv(bits[i], exps[i], nm);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; d_valid = 1'b1; d_in = 1'b1;
    go(1'b0, "det_in_rst");
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);

    // Reset defaults: 1010, overlapping.
    stream(8'b0010_1010, 8'b0000_0101, 6, "t1_det");
    chk("t1_cnt", 32'(cnt_a), 32'd2);

    // Non-overlapping 1010.
    cnt_clr = 1'b1; go(1'b0, "clr_det");
    load(8'b0000_1010, 4'd4, 1'b0);
    stream(8'b0010_1010, 8'b0000_0100, 6, "t2_det");
    chk("t2_cnt", 32'(cnt_a), 32'd1);

    // Full-length pattern with an idle gap mid-pattern.
    cnt_clr = 1'b1; go(1'b0, "clr_det");
    load(8'b1101_0011, 4'd8, 1'b1);
    stream(8'b0000_1101, 8'b0000_0000, 4, "t3_det_a");
    repeat (3) go(1'b0, "t3_gap");
    stream(8'b0000_0011, 8'b0000_0001, 4, "t3_det_b");
    chk("t3_cnt", 32'(cnt_a), 32'd1);

    // Illegal loads leave config and history alone.
    load(8'b0000_1010, 4'd4, 1'b1);
    stream(8'b0000_0010, 8'b0000_0000, 2, "t4_pre");
    cfg_load = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF;
    go(1'b0, "ill0_det");
    chk("ill0_err", 32'(err_a), 32'd1);
    bitv(1'b1, 1'b0, "t4_b1");
    chk("ill0_err_clr", 32'(err_a), 32'd0);
    bitv(1'b0, 1'b1, "t4_m1");
    cfg_load = 1'b1; cfg_len = 4'd9; cfg_pattern = 8'hFF;
    go(1'b0, "ill9_det");
    chk("ill9_err", 32'(err_a), 32'd1);
    bitv(1'b1, 1'b0, "t4_b2");
    chk("ill9_err_clr", 32'(err_a), 32'd0);
    bitv(1'b0, 1'b1, "t4_m2");
    chk("t4_cnt", 32'(cnt_a), 32'd3);

    // Bit coincident with cfg_load is dropped; clear beats a coincident match.
    load(8'b0000_1010, 4'd4, 1'b1);
    stream(8'b0000_0101, 8'b0000_0000, 3, "t5_pre");
    cfg_load = 1'b1; cfg_len = 4'd0; d_valid = 1'b1; d_in = 1'b0;
    go(1'b0, "drop_det");
    bitv(1'b0, 1'b1, "after_drop");
    bitv(1'b1, 1'b0, "t5_b");
    cnt_clr = 1'b1;
    bitv(1'b0, 1'b1, "clr_match_det");
    chk("clr_match_cnt", 32'(cnt_a), 32'd0);

    // Length-1 pattern and 2-bit counter saturation.
    load(8'b0000_0001, 4'd1, 1'b0);
    stream(8'b0001_1111, 8'b0001_1111, 5, "t6_det");
    chk("t6_cnt_sat", 32'(cnt_b), 32'd3);
    chk("t6_cnt_wide", 32'(cnt_a), 32'd5);
    bitv(1'b0, 1'b0, "t6_zero");

    // Reset during a partial match discards it.
    load(8'b0000_1010, 4'd4, 1'b1);
    stream(8'b0000_0101, 8'b0000_0000, 3, "t7_pre");
    rst = 1'b1; d_valid = 1'b1; d_in = 1'b0;
    go(1'b0, "rst_gate_det");
    bitv(1'b0, 1'b0, "post_rst");
    chk("t7_cnt", 32'(cnt_a), 32'd0);
    stream(8'b0000_1010, 8'b0000_0001, 4, "t7_det");

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
